// File: rtl/uart_report_pkg.sv
// Shared definitions for the UART report multiplexer.
// Holds the FSM state encoding, the ASCII constants used to build each
// report frame, and two small helpers (decimal power, nibble to ASCII).
package uart_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_CONV = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    localparam logic [7:0] ASC_C     = 8'h43;  // 'C'
    localparam logic [7:0] ASC_COLON = 8'h3A;  // ':'
    localparam logic [7:0] ASC_DOT   = 8'h2E;  // '.'
    localparam logic [7:0] ASC_STAR  = 8'h2A;  // '*'
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;  // '0'
    localparam logic [7:0] ASC_A     = 8'h41;  // 'A'

    // 10^n, used to find the largest printable decimal value.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // One digit (decimal or hex) to its printable character.
    function automatic logic [7:0] nib_ascii(input logic [3:0] d);
        if (d < 4'd10) return ASC_0 + {4'b0000, d};
        else           return ASC_A + {4'b0000, d} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_report_mux_bin2bcd.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : loads bin and begins a conversion of exactly VAL_W shifts
//   bin        : binary input, sampled when start is high
//   bcd        : DIGITS packed BCD digits, most significant digit on top;
//                stays stable after done until the next start
//   done       : one-cycle pulse on the cycle after the final shift
// Digits above DIGITS are dropped; the lower digits remain correct because
// the add-3 corrections only ever carry upward.
module bin2bcd_seq #(
    parameter int VAL_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    sh_q,  sh_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = CNT_W'(VAL_W);
        end else if (cnt_q != '0) begin
            bcd_d  = {adj[4*DIGITS-2:0], sh_q[VAL_W-1]};
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/uart_report_mux.sv
// uart_report_mux: latches per-channel measurement samples and prints each
// one as an ASCII frame "C<n>:<digits>\r\n" on a uart_tx byte interface.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   ch_valid[NUM_CH]    : one-cycle sample strobe per channel
//   ch_value            : packed samples, channel i at [i*VAL_W +: VAL_W]
//   hex_mode            : print hex digits instead of decimal (sampled at grant)
//   tx_data / tx_data_valid / tx_data_ready : byte output handshake
//   overrun[NUM_CH]     : sticky, a pending sample was overwritten
//   busy                : FSM not in IDLE
//   dbg_state           : current FSM state
//   dbg_pending         : per-channel pending bits
// Handshake: tx_data_valid/tx_data hold steady until tx_data_ready is seen
// high at a rising edge; that edge transfers the byte, and the next byte of
// the frame is presented on the following cycle without a gap.
module uart_report_mux
    import uart_report_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int VAL_W  = 13,
    parameter int DIGITS = 4,
    parameter int DP_POS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH*VAL_W-1:0] ch_value,
    input  logic                    hex_mode,
    output logic [7:0]              tx_data,
    output logic                    tx_data_valid,
    input  logic                    tx_data_ready,
    output logic [NUM_CH-1:0]       overrun,
    output logic                    busy,
    output state_e                  dbg_state,
    output logic [NUM_CH-1:0]       dbg_pending
);

    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FRAME_LEN = 5 + DIGITS + ((DP_POS > 0) ? 1 : 0);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int MAX_DEC   = pow10(DIGITS) - 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic [CH_W-1:0]      ptr_q, ch_q, grant;
    logic                 hex_q, star_q;
    logic [VAL_W-1:0]     work_q, hold_sel;
    logic                 grant_en;
    logic [NUM_CH-1:0]    pending_w, overrun_w;
    logic [VAL_W-1:0]     hold_w [NUM_CH];
    logic [4*DIGITS-1:0]  bcd_w, digits_w;
    logic                 conv_done;

    // Per-channel hold register, pending and sticky overrun. A strobe wins
    // over the grant clear, so a sample arriving in the grant cycle stays
    // pending; it is not an overrun because the old value was already taken.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [VAL_W-1:0] hold_q;
        logic             pend_q, ovr_q, clr;

        assign clr = grant_en && (grant == CH_W'(i));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold_q <= '0;
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else if (ch_valid[i]) begin
                hold_q <= ch_value[i*VAL_W +: VAL_W];
                pend_q <= 1'b1;
                if (pend_q && !clr) ovr_q <= 1'b1;
            end else if (clr) begin
                pend_q <= 1'b0;
            end
        end

        assign hold_w[i]    = hold_q;
        assign pending_w[i] = pend_q;
        assign overrun_w[i] = ovr_q;
    end

    // Round-robin pick: first pending channel at or after ptr_q.
    always_comb begin
        grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pending_w[(int'(ptr_q) + k) % NUM_CH]) grant = CH_W'((int'(ptr_q) + k) % NUM_CH);
        end
    end

    assign hold_sel = hold_w[grant];

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (grant_en),
        .bin   (hold_sel),
        .bcd   (bcd_w),
        .done  (conv_done)
    );

    // Hex mode prints the low 4*DIGITS bits of the working value directly.
    assign digits_w = hex_q ? (4*DIGITS)'(work_q) : bcd_w;

    function automatic logic [7:0] frame_byte(input int idx, input logic [CH_W-1:0] ch,
                                              input logic [4*DIGITS-1:0] digs, input logic star);
        int         p;
        int         dn;
        logic [3:0] nib;
        p   = idx - 3;
        dn  = 0;
        nib = '0;
        frame_byte = ASC_LF;
        if (idx == 0)                                   frame_byte = ASC_C;
        else if (idx == 1)                              frame_byte = 8'(int'(ASC_0) + int'(ch));
        else if (idx == 2)                              frame_byte = ASC_COLON;
        else if (idx == FRAME_LEN - 2)                  frame_byte = ASC_CR;
        else if (idx == FRAME_LEN - 1)                  frame_byte = ASC_LF;
        else if (DP_POS > 0 && p == DIGITS - DP_POS)    frame_byte = ASC_DOT;
        else if (star)                                  frame_byte = ASC_STAR;
        else begin
            // Digits after the point sit one byte further along the frame.
            dn  = (DP_POS > 0 && p > DIGITS - DP_POS) ? p - 1 : p;
            nib = digs[4*(DIGITS-1-dn) +: 4];
            frame_byte = nib_ascii(nib);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        grant_en = 1'b0;
        case (state_q)
            ST_IDLE: if (|pending_w) state_d = ST_ARB;
            ST_ARB: begin
                if (|pending_w) begin
                    grant_en = 1'b1;
                    state_d  = ST_CONV;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    data_d  = frame_byte(0, ch_q, digits_w, star_q);
                    valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_data_ready) begin
                    if (int'(idx_q) == FRAME_LEN - 1) begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                        state_d = (|pending_w) ? ST_ARB : ST_IDLE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = frame_byte(int'(idx_q) + 1, ch_q, digits_w, star_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            ch_q    <= '0;
            hex_q   <= 1'b0;
            star_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            if (grant_en) begin
                ptr_q  <= CH_W'((int'(grant) + 1) % NUM_CH);
                ch_q   <= grant;
                hex_q  <= hex_mode;
                work_q <= hold_sel;
                // Out-of-range only matters for decimal; hex simply truncates.
                star_q <= !hex_mode && (64'(hold_sel) > 64'(MAX_DEC));
            end
        end
    end

    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;
    assign overrun       = overrun_w;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;
    assign dbg_pending   = pending_w;

endmodule

// File: tb/tb_uart_report_mux.sv
module tb_uart_report_mux;
    import uart_report_pkg::*;

    localparam int VAL_W = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]         ch_valid, ch_valid3;
    logic [2*VAL_W-1:0] ch_value, ch_value3;
    logic               hex_mode;
    logic               tx_ready;
    logic [7:0]         tx_data, tx_data3;
    logic               tx_valid, tx_valid3;
    logic [1:0]         overrun, overrun3;
    logic               busy, busy3;
    state_e             dbg_state, dbg_state3;
    logic [1:0]         dbg_pending, dbg_pending3;

    uart_report_mux u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_valid      (ch_valid),
        .ch_value      (ch_value),
        .hex_mode      (hex_mode),
        .tx_data       (tx_data),
        .tx_data_valid (tx_valid),
        .tx_data_ready (tx_ready),
        .overrun       (overrun),
        .busy          (busy),
        .dbg_state     (dbg_state),
        .dbg_pending   (dbg_pending)
    );

    uart_report_mux #(.DIGITS(3), .DP_POS(0)) u_dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_valid      (ch_valid3),
        .ch_value      (ch_value3),
        .hex_mode      (1'b0),
        .tx_data       (tx_data3),
        .tx_data_valid (tx_valid3),
        .tx_data_ready (tx_ready),
        .overrun       (overrun3),
        .busy          (busy3),
        .dbg_state     (dbg_state3),
        .dbg_pending   (dbg_pending3)
    );

    // ---------------- scoreboard ----------------
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    bit         use3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobe(input bit sel3, input logic [1:0] mask,
                          input logic [VAL_W-1:0] v0, input logic [VAL_W-1:0] v1);
        @(negedge clk);
        if (sel3) begin
            ch_valid3 = mask;
            ch_value3 = {v1, v0};
        end else begin
            ch_valid  = mask;
            ch_value  = {v1, v0};
        end
        @(negedge clk);
        ch_valid  = '0;
        ch_valid3 = '0;
    endtask

    // Consumes exp_q from the selected DUT; cycle 1 is the negedge after the
    // first edge following the strobe edge.
    task automatic recv_frame(input int lat_exp, input bit rand_ready);
        int         cyc;
        bit         seen;
        logic       pv, pr, v;
        logic [7:0] pd, d;
        cyc = 0; seen = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
        while (exp_q.size() > 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            v = use3 ? tx_valid3 : tx_valid;
            d = use3 ? tx_data3  : tx_data;
            if (pv && !pr) begin
                check("hold_valid", v, 1);
                check("hold_data", d, pd);
            end
            if (v && !seen) begin
                seen = 1'b1;
                if (lat_exp > 0) check("latency", cyc, lat_exp);
            end
            if (v && tx_ready) check("byte", d, exp_q.pop_front());
            pv = v; pr = tx_ready; pd = d;
        end
        if (exp_q.size() > 0) begin
            check("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        check("valid_drop", use3 ? tx_valid3 : tx_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ch_valid = '0; ch_value = '0; ch_valid3 = '0; ch_value3 = '0;
        hex_mode = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",    tx_data, 0);
        check("rst_valid",   tx_valid, 0);
        check("rst_busy",    busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_pending", dbg_pending, 0);
        check("rst_state",   dbg_state, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic decimal frame and first-byte latency
        strobe(1'b0, 2'b01, 13'd1234, 13'd0);
        load_exp("C0:1.234");
        recv_frame(16, 1'b0);
        check("idle_busy", busy, 0);

        // simultaneous strobes, round robin from channel 0
        do_reset(1);
        strobe(1'b0, 2'b11, 13'd5, 13'd8191);
        load_exp("C0:0.005");
        recv_frame(16, 1'b0);
        load_exp("C1:8.191");
        recv_frame(0, 1'b0);
        check("no_overrun", overrun, 2'b00);

        // out-of-range decimal on the 3-digit, no-point instance
        use3 = 1'b1;
        strobe(1'b1, 2'b01, 13'd1000, 13'd0);
        load_exp("C0:***");
        recv_frame(16, 1'b0);
        use3 = 1'b0;

        // hex mode
        hex_mode = 1'b1;
        strobe(1'b0, 2'b01, 13'h1ABC, 13'd0);
        load_exp("C0:1.ABC");
        recv_frame(16, 1'b0);
        hex_mode = 1'b0;

        // random ready, then channel 1 strobed three times mid-frame
        strobe(1'b0, 2'b01, 13'd4321, 13'd0);
        load_exp("C0:4.321");
        fork
            recv_frame(16, 1'b1);
            begin
                logic [VAL_W-1:0] vals [3];
                vals[0] = 13'd100; vals[1] = 13'd200; vals[2] = 13'd777;
                repeat (17) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    ch_valid[1] = 1'b1;
                    ch_value[2*VAL_W-1:VAL_W] = vals[k];
                    @(negedge clk);
                    ch_valid[1] = 1'b0;
                    @(negedge clk);
                end
            end
        join
        check("overrun_ch1", overrun, 2'b10);
        load_exp("C1:0.777");
        recv_frame(0, 1'b1);

        // reset pulse while the 4th byte is presented
        do_reset(1);
        check("overrun_cleared", overrun, 2'b00);
        strobe(1'b0, 2'b01, 13'd1234, 13'd0);
        tx_ready = 1'b1;
        begin
            bit seen;
            bit bad;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (tx_valid) seen = 1'b1;
            end
            check("wait_valid", seen, 1);
            repeat (3) @(negedge clk);
            check("fourth_byte", tx_data, 8'h31);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_valid",   tx_valid, 0);
            check("abort_pending", dbg_pending, 0);
            check("abort_busy",    busy, 0);
            bad = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (tx_valid) bad = 1'b1;
            end
            check("no_resume", bad, 0);
        end
        strobe(1'b0, 2'b01, 13'd999, 13'd0);
        load_exp("C0:0.999");
        recv_frame(16, 1'b0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_report_mux.md
UART_REPORT_MUX -- requirements
Module: uart_report_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of measurement channels (1..8).
REQ-002 SHALL have parameter VAL_W, default 13, binary width of each channel value.
REQ-003 SHALL have parameter DIGITS, default 4, decimal digits printed per value (1..5).
REQ-004 SHALL have parameter DP_POS, default 3, digits right of the decimal point (0 = no point, < DIGITS).
REQ-005 SHALL have clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ch_valid  input  NUM_CH  per-channel one-cycle sample strobe.
REQ-008 SHALL have ch_value  input  NUM_CH*VAL_W  packed channel values; channel i at bits [i*VAL_W +: VAL_W].
REQ-009 SHALL have hex_mode  input  1  1 = print DIGITS hex digits instead of decimal; sampled at grant.
REQ-010 SHALL have tx_data  output  8  ASCII byte to the uart_tx byte interface.
REQ-011 SHALL have tx_data_valid  output  1  tx_data holds a byte to send.
REQ-012 SHALL have tx_data_ready  input  1  uart_tx accepts the byte this cycle.
REQ-013 SHALL have overrun  output  NUM_CH  sticky flag: a pending sample was overwritten before it was sent.
REQ-014 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-015 ch_valid[i] SHALL latch ch_value slice i into hold register i and set pending[i] on the next edge.
REQ-016 ch_valid[i] while pending[i]=1 SHALL overwrite the hold register and set overrun[i]; the newest value is sent.
REQ-017 FSM states SHALL be IDLE, ARB, CONV, SEND; IDLE->ARB when any pending bit is set.
REQ-018 ARB SHALL grant in round-robin order, starting after the last served channel (channel 0 first after reset). It SHALL copy the hold register to a working register, clear pending[grant] and go to CONV, all in 1 cycle.
REQ-019 A strobe on the granted channel in the grant cycle SHALL set pending again; it SHALL NOT corrupt the working value.
REQ-020 CONV SHALL run a sequential shift-add-3 binary-to-BCD conversion for exactly VAL_W cycles. In hex_mode it SHALL pass nibbles directly with the same cycle count.
REQ-021 If the decimal value exceeds 10^DIGITS-1, every digit byte SHALL be '*' (0x2A). In hex mode, bits above 4*DIGITS SHALL be truncated.
REQ-022 SEND SHALL emit, in order: 'C', '0'+channel, ':', the digits MSB first (with '.' inserted before the last DP_POS digits), then CR and LF. Hex digits use '0'-'9','A'-'F'. Leading zeros are printed.
REQ-023 Frame length SHALL be 5+DIGITS+(DP_POS>0); a byte index counter SHALL select the byte.
REQ-024 tx_data_valid SHALL rise on the cycle after CONV ends. tx_data and tx_data_valid SHALL stay stable until tx_data_ready=1, and the byte transfers on that cycle.
REQ-025 After each transfer the next byte SHALL be presented on the next cycle with valid held high. No gap cycles are allowed within a frame.
REQ-026 After the LF transfer, tx_data_valid SHALL drop. The FSM SHALL go to ARB if any pending bit is set, otherwise to IDLE.
REQ-027 From a strobe into idle, the first tx_data_valid SHALL occur exactly VAL_W+3 clock edges later.
REQ-028 Simultaneous strobes on several channels SHALL all be latched; frames follow in round-robin order with no loss.

Reset
REQ-029 While rst_n=0 at an edge, the block SHALL reset to: tx_data=0, tx_data_valid=0, busy=0, overrun=0, pending=0, state IDLE, round-robin pointer to channel 0, byte counter 0.
REQ-030 Reset mid-frame SHALL abort the frame. tx_data_valid SHALL be low from the first reset edge, and no partial frame resumes.

Structure
REQ-031 A shared package uart_report_pkg SHALL hold the state encoding and the ASCII constants ('C', ':', '.', '*', CR, LF, '0', 'A').
REQ-032 Conversion SHALL be one sub-module, bin2bcd_seq (parameters VAL_W, DIGITS; ports start, bin, bcd, done).
REQ-033 The per-channel hold, pending and overrun logic SHALL be a generate loop over NUM_CH.

Verification
REQ-034 Default parameters, ch0 strobe with 1234, tx_data_ready=1 -> bytes "C0:1.234\r\n", first valid 16 cycles after the strobe.
REQ-035 ch0=5 and ch1=8191 strobed in the same cycle -> "C0:0.005\r\n" then "C1:8.191\r\n", with no overrun.
REQ-036 DIGITS=3, DP_POS=0, value 1000 -> "C0:***\r\n".
REQ-037 hex_mode=1, value 0x1ABC -> "C0:1.ABC\r\n".
REQ-038 tx_data_ready toggled randomly -> tx_data stable while valid and not ready, and the frame is intact. Then ch1 strobed 3 times during a ch0 frame -> overrun[1]=1 and only the last value is sent.
REQ-039 rst_n low for 1 cycle at the 4th byte -> tx_data_valid=0 on the next cycle, pending=0, and the next strobe yields a full frame.
